// File: rtl/axil_ctrl_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : axil_ctrl_bank_if
//  Purpose  : AXI4-Lite slave bundle (no WSTRB, no PROT) used by the
//             control bank. Carries the AW, W, B, AR and R channels.
//  Modports : master - drives addresses/data/valids and B/R readies
//             slave  - drives AW/W/AR readies and the B/R responses
//  Revision : 1.0 - initial release
// ============================================================================
interface axil_ctrl_bank_if #(
    parameter int AW = 8
);
    logic [AW-1:0] S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [AW-1:0] S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axil_ctrl_bank.sv
`default_nettype none
// ============================================================================
//  Module   : axil_ctrl_bank
//  Purpose  : AXI4-Lite register bank that launches and monitors NCH
//             engine channels.
//             Index 0 START  (W, reads 0)   one-cycle start pulse per bit
//             Index 1 STATUS (R)            live busy levels
//             Index 2 DONE   (R/W1C)        sticky completion flags
//             Index 3 IRQ_EN (R/W)          interrupt enables
//             Other indices answer DECERR.
//  Ports    : clk     - sole clock, rising edge
//             resetn  - asynchronous active-low reset
//             s_axi   - AXI4-Lite slave (axil_ctrl_bank_if.slave)
//             start   - per-channel one-cycle start pulse
//             busy    - per-channel busy level from the engines
//             done    - per-channel one-cycle completion pulse
//             irq     - registered level interrupt |(DONE & IRQ_EN)
//  Revision : 1.0 - initial release
// ============================================================================
module axil_ctrl_bank #(
    parameter int AW  = 8,
    parameter int NCH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    axil_ctrl_bank_if.slave    s_axi,
    output logic [NCH-1:0]     start,
    input  logic [NCH-1:0]     busy,
    input  logic [NCH-1:0]     done,
    output logic               irq
);

    localparam int IW = AW - 2;

    localparam logic [IW-1:0] IDX_START  = IW'(0);
    localparam logic [IW-1:0] IDX_STATUS = IW'(1);
    localparam logic [IW-1:0] IDX_DONE   = IW'(2);
    localparam logic [IW-1:0] IDX_IRQEN  = IW'(3);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_t          wr_state_q, wr_state_d;
    logic [IW-1:0]      awaddr_q,   awaddr_d;
    logic [NCH-1:0]     wdata_q,    wdata_d;
    logic [1:0]         bresp_q,    bresp_d;
    logic [NCH-1:0]     start_q,    start_d;
    logic [NCH-1:0]     done_q,     done_d;
    logic [NCH-1:0]     irq_en_q,   irq_en_d;
    logic               irq_q,      irq_d;
    logic               rvalid_q,   rvalid_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic [1:0]         rresp_q,    rresp_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_awready;
    logic               w_wready;
    logic               w_arready;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_commit;
    logic [IW-1:0]      w_cm_idx;
    logic [NCH-1:0]     w_cm_data;
    logic [NCH-1:0]     w_done_clr;
    logic [IW-1:0]      w_ar_idx;

    // Address bits [1:0] and write-data bits above NCH carry no meaning.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, s_axi.S_AXI_WDATA,
                             s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] zext(input logic [NCH-1:0] v);
        logic [31:0] r;
        r          = '0;
        r[NCH-1:0] = v;
        return r;
    endfunction

    // Readies come only from state and the reset pin, never from VALIDs.
    // Gating with resetn forces them low for the whole reset window and
    // lets them rise as soon as reset is released.
    assign w_awready = resetn & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_HAVE_W));
    assign w_wready  = resetn & ((wr_state_q == WR_IDLE) | (wr_state_q == WR_HAVE_AW));
    assign w_arready = resetn & ~rvalid_q;

    assign w_aw_hs = s_axi.S_AXI_AWVALID & w_awready;
    assign w_w_hs  = s_axi.S_AXI_WVALID  & w_wready;
    assign w_ar_hs = s_axi.S_AXI_ARVALID & w_arready;

    // The write that completes the address/data pair is committed on the
    // same edge, so pick the half that is still on the bus.
    assign w_cm_idx  = (wr_state_q == WR_HAVE_AW) ? awaddr_q
                                                  : s_axi.S_AXI_AWADDR[AW-1:2];
    assign w_cm_data = (wr_state_q == WR_HAVE_W)  ? wdata_q
                                                  : s_axi.S_AXI_WDATA[NCH-1:0];
    assign w_ar_idx  = s_axi.S_AXI_ARADDR[AW-1:2];

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        w_commit   = 1'b0;

        if (w_aw_hs) begin
            awaddr_d = s_axi.S_AXI_AWADDR[AW-1:2];
        end
        if (w_w_hs) begin
            wdata_d = s_axi.S_AXI_WDATA[NCH-1:0];
        end

        case (wr_state_q)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit   = 1'b1;
                    wr_state_d = WR_RESP;
                end else if (w_aw_hs) begin
                    wr_state_d = WR_HAVE_AW;
                end else if (w_w_hs) begin
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_w_hs) begin
                    w_commit   = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (w_aw_hs) begin
                    w_commit   = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register effects of a committed write
    // ------------------------------------------------------------------
    always_comb begin
        bresp_d    = bresp_q;
        start_d    = '0;
        irq_en_d   = irq_en_q;
        w_done_clr = '0;

        if (w_commit) begin
            case (w_cm_idx)
                IDX_START: begin
                    // Idle channels start even when a sibling is refused.
                    start_d = w_cm_data & ~busy;
                    bresp_d = (|(w_cm_data & busy)) ? RESP_SLVERR : RESP_OKAY;
                end
                IDX_STATUS: begin
                    bresp_d = RESP_OKAY;
                end
                IDX_DONE: begin
                    w_done_clr = w_cm_data;
                    bresp_d    = RESP_OKAY;
                end
                IDX_IRQEN: begin
                    irq_en_d = w_cm_data;
                    bresp_d  = RESP_OKAY;
                end
                default: begin
                    bresp_d = RESP_DECERR;
                end
            endcase
        end

        // A completion arriving with its own clear wins: the flag stays set.
        done_d = (done_q & ~w_done_clr) | done;
        irq_d  = |(done_q & irq_en_q);
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (w_ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (w_ar_idx)
                IDX_START:  rdata_d = 32'd0;
                IDX_STATUS: rdata_d = zext(busy);
                IDX_DONE:   rdata_d = zext(done_q);
                IDX_IRQEN:  rdata_d = zext(irq_en_q);
                default: begin
                    rdata_d = 32'd0;
                    rresp_d = RESP_DECERR;
                end
            endcase
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= WR_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
            start_q    <= '0;
            done_q     <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            bresp_q    <= bresp_d;
            start_q    <= start_d;
            done_q     <= done_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi.S_AXI_AWREADY = w_awready;
    assign s_axi.S_AXI_WREADY  = w_wready;
    assign s_axi.S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = w_arready;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign start               = start_q;
    assign irq                 = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_ctrl_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_ctrl_bank
//  Purpose  : Self-checking bench for axil_ctrl_bank (AW=8, NCH=4).
//             Table of single transactions plus hand-written sequences for
//             interrupt/W1C, split write ordering, and reset abandonment.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axil_ctrl_bank;

    logic       clk;
    logic       resetn;
    logic [3:0] start;
    logic [3:0] busy;
    logic [3:0] done;
    logic       irq;

    int total = 0;
    int bad   = 0;

    axil_ctrl_bank_if #(.AW(8)) bus ();

    axil_ctrl_bank #(.AW(8), .NCH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .s_axi  (bus),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  busy;
        logic [1:0]  resp;
        logic [31:0] exp;     // start pulse for writes, RDATA for reads
    } vec_t;

    vec_t vt[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [45:0] all_outs();
        return {start, irq, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_BRESP,
                bus.S_AXI_RRESP, bus.S_AXI_RDATA};
    endfunction

    task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                            output logic [1:0] resp, output logic [3:0] st);
        logic hs_aw, hs_w;
        bit   got;
        got  = 1'b0;
        resp = 2'b01;
        st   = 4'h0;
        @(negedge clk);
        bus.S_AXI_AWADDR  = a;
        bus.S_AXI_WDATA   = d;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            hs_aw = bus.S_AXI_AWVALID & bus.S_AXI_AWREADY;
            hs_w  = bus.S_AXI_WVALID  & bus.S_AXI_WREADY;
            @(negedge clk);
            if (hs_aw) bus.S_AXI_AWVALID = 1'b0;
            if (hs_w)  bus.S_AXI_WVALID  = 1'b0;
            if (bus.S_AXI_BVALID) begin
                got  = 1'b1;
                resp = bus.S_AXI_BRESP;
                st   = start;
            end
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL write_timeout: addr %0h got no BVALID required BVALID=1", a);
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [1:0] resp, output logic [31:0] data);
        logic hs;
        bit   got;
        got  = 1'b0;
        resp = 2'b01;
        data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            hs = bus.S_AXI_ARVALID & bus.S_AXI_ARREADY;
            @(negedge clk);
            if (hs) bus.S_AXI_ARVALID = 1'b0;
            if (bus.S_AXI_RVALID) begin
                got  = 1'b1;
                resp = bus.S_AXI_RRESP;
                data = bus.S_AXI_RDATA;
            end
        end
        bus.S_AXI_ARVALID = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL read_timeout: addr %0h got no RVALID required RVALID=1", a);
        end
    endtask

    initial begin
        logic [1:0]  r;
        logic [3:0]  st;
        logic [31:0] d;
        int          bcnt;
        logic [3:0]  st_acc;

        // {wr, addr, wdata, busy, resp, exp}
        vt[0]  = '{1'b1, 8'h00, 32'h0000_0005, 4'b0000, 2'd0, 32'h5};  // start 0101
        vt[1]  = '{1'b1, 8'h00, 32'h0000_0003, 4'b0010, 2'd2, 32'h1};  // busy ch1 refused
        vt[2]  = '{1'b1, 8'h00, 32'h0000_00F0, 4'b0000, 2'd0, 32'h0};  // bits >= NCH ignored
        vt[3]  = '{1'b0, 8'h04, 32'h0,         4'b1010, 2'd0, 32'hA};  // STATUS = busy
        vt[4]  = '{1'b0, 8'h05, 32'h0,         4'b1111, 2'd0, 32'hF};  // low addr bits ignored
        vt[5]  = '{1'b1, 8'h0C, 32'hFFFF_FFF6, 4'b0000, 2'd0, 32'h0};  // IRQ_EN <= 6
        vt[6]  = '{1'b0, 8'h0C, 32'h0,         4'b0000, 2'd0, 32'h6};
        vt[7]  = '{1'b0, 8'h00, 32'h0,         4'b0000, 2'd0, 32'h0};  // START reads 0
        vt[8]  = '{1'b0, 8'h40, 32'h0,         4'b0000, 2'd3, 32'h0};  // DECERR read
        vt[9]  = '{1'b1, 8'h40, 32'hFFFF_FFFF, 4'b0000, 2'd3, 32'h0};  // DECERR write
        vt[10] = '{1'b0, 8'h0C, 32'h0,         4'b0000, 2'd0, 32'h6};  // unchanged
        vt[11] = '{1'b1, 8'h10, 32'h0000_000F, 4'b0000, 2'd3, 32'h0};  // index 4
        vt[12] = '{1'b1, 8'h04, 32'h0000_000F, 4'b0000, 2'd0, 32'h0};  // STATUS write no-op
        vt[13] = '{1'b0, 8'hFC, 32'h0,         4'b0000, 2'd3, 32'h0};  // top index
        vt[14] = '{1'b1, 8'h00, 32'h0000_0000, 4'b1111, 2'd0, 32'h0};  // nothing requested
        vt[15] = '{1'b1, 8'h00, 32'h0000_0004, 4'b0100, 2'd2, 32'h0};  // only busy channel

        resetn            = 1'b1;
        busy              = 4'h0;
        done              = 4'h0;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b0;

        #2 resetn = 1'b0;
        #1 check("reset_outputs", 64'(all_outs()), 64'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1 check("readies_after_reset",
                 {61'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 64'h7);

        // ---------------- table ----------------
        for (int i = 0; i < 16; i++) begin
            busy = vt[i].busy;
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].wdata, r, st);
                check($sformatf("vec%0d_bresp", i), 64'(r), 64'(vt[i].resp));
                check($sformatf("vec%0d_start", i), 64'(st), 64'(vt[i].exp));
                @(negedge clk);
                check($sformatf("vec%0d_start_once", i), 64'(start), 64'h0);
            end else begin
                do_read(vt[i].addr, r, d);
                check($sformatf("vec%0d_rresp", i), 64'(r), 64'(vt[i].resp));
                check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vt[i].exp));
            end
        end
        busy = 4'h0;

        // ---------------- DONE / irq ----------------
        do_write(8'h0C, 32'h4, r, st);
        @(negedge clk) done = 4'b0100;
        @(negedge clk) done = 4'b0000;
        check("irq_lags_done", 64'(irq), 64'h0);
        @(negedge clk);
        check("irq_set", 64'(irq), 64'h1);
        do_read(8'h08, r, d);
        check("done_read", 64'(d), 64'h4);
        do_write(8'h08, 32'h4, r, st);
        check("irq_before_clear_seen", 64'(irq), 64'h1);
        @(negedge clk);
        check("irq_cleared", 64'(irq), 64'h0);
        do_read(8'h08, r, d);
        check("done_after_w1c", 64'(d), 64'h0);

        // clear and completion on the same edge: flag stays set
        @(negedge clk);
        bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_WDATA = 32'h4;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
        done = 4'b0100;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; done = 4'b0000;
        check("simul_bvalid", 64'(bus.S_AXI_BVALID), 64'h1);
        @(negedge clk);
        do_read(8'h08, r, d);
        check("done_set_wins", 64'(d), 64'h4);

        // read of DONE alongside its clear returns the old value
        @(negedge clk);
        bus.S_AXI_ARADDR = 8'h08; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
        bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_WDATA = 32'h4;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("concurrent_rvalid", 64'(bus.S_AXI_RVALID), 64'h1);
        check("concurrent_rdata_preclear", 64'(bus.S_AXI_RDATA), 64'h4);
        check("concurrent_bvalid", 64'(bus.S_AXI_BVALID), 64'h1);
        @(negedge clk);
        do_read(8'h08, r, d);
        check("done_after_concurrent_clear", 64'(d), 64'h0);

        // ---------------- W before AW, slow BREADY ----------------
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_WDATA  = 32'h2;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        check("have_w_readies",
              {62'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 64'h2);
        repeat (2) @(negedge clk);
        check("no_bvalid_before_aw", 64'(bus.S_AXI_BVALID), 64'h0);
        bus.S_AXI_AWADDR  = 8'h00;
        bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("split_start", 64'(start), 64'h2);
        check("split_bresp", 64'(bus.S_AXI_BRESP), 64'h0);
        bcnt   = 0;
        st_acc = 4'h0;
        for (int k = 0; k < 5; k++) begin
            if (bus.S_AXI_BVALID && !bus.S_AXI_AWREADY && !bus.S_AXI_WREADY) bcnt++;
            if (k > 0) st_acc = st_acc | start;
            if (k < 4) @(negedge clk);
        end
        check("bvalid_held_5", 64'(bcnt), 64'd5);
        check("split_start_single", 64'(st_acc), 64'h0);
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        check("bvalid_released", 64'(bus.S_AXI_BVALID), 64'h0);

        // ---------------- reset mid-transaction ----------------
        do_write(8'h0C, 32'hF, r, st);
        @(negedge clk) done = 4'b0001;
        @(negedge clk) done = 4'b0000;
        @(negedge clk);
        check("irq_before_reset", 64'(irq), 64'h1);
        bus.S_AXI_AWADDR  = 8'h00;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        check("have_aw_readies",
              {62'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 64'h1);
        resetn           = 1'b0;
        bus.S_AXI_WDATA  = 32'h1;
        bus.S_AXI_WVALID = 1'b1;
        #1 check("midreset_outputs", 64'(all_outs()), 64'h0);
        @(negedge clk);
        check("midreset_outputs_held", 64'(all_outs()), 64'h0);
        bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1 check("readies_after_release",
                 {61'h0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 64'h7);
        st_acc = 4'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            st_acc = st_acc | start;
        end
        check("no_start_after_reset", 64'(st_acc), 64'h0);
        do_read(8'h0C, r, d);
        check("irq_en_cleared", 64'(d), 64'h0);
        do_read(8'h08, r, d);
        check("done_cleared", 64'(d), 64'h0);
        check("irq_after_reset", 64'(irq), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axil_ctrl_bank.md
AXIL_CTRL_BANK -- requirements
Module: axil_ctrl_bank

Interface
REQ-001 The block SHALL use parameter AW, default 8, meaning AXI4-Lite address width (min 4).
REQ-002 The block SHALL use parameter NCH, default 4, meaning number of controlled channels (1..32).
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  output  NCH  per-channel one-cycle start pulse.
REQ-006 busy  input  NCH  per-channel busy level from controlled engine.
REQ-007 done  input  NCH  per-channel one-cycle completion pulse.
REQ-008 irq  output  1  level interrupt.
REQ-009 S_AXI_AWADDR  input  AW  write address.
REQ-010 S_AXI_AWVALID  input  1 / S_AXI_AWREADY  output  1  AW handshake.
REQ-011 S_AXI_WDATA  input  32  write data (full-word writes only; no WSTRB).
REQ-012 S_AXI_WVALID  input  1 / S_AXI_WREADY  output  1  W handshake.
REQ-013 S_AXI_BRESP  output  2 / S_AXI_BVALID  output  1 / S_AXI_BREADY  input  1  write response.
REQ-014 S_AXI_ARADDR  input  AW / S_AXI_ARVALID  input  1 / S_AXI_ARREADY  output  1  read address.
REQ-015 S_AXI_RDATA  output  32 / S_AXI_RRESP  output  2 / S_AXI_RVALID  output  1 / S_AXI_RREADY  input  1  read data.

Function
REQ-016 Register index SHALL be ADDR[AW-1:2]; ADDR[1:0] ignored.
REQ-017 Map: 0 START (W, reads 0), 1 STATUS (R, = busy), 2 DONE (R/W1C sticky), 3 IRQ_EN (R/W); bits >= NCH read 0, writes ignored.
REQ-018 Any other index SHALL return DECERR (3); reads of it return RDATA 0, writes have no effect.
REQ-019 Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP; AWREADY high in IDLE/HAVE_W, WREADY high in IDLE/HAVE_AW.
REQ-020 AW and W SHALL be accepted in either order or same cycle; address/data latched on their handshake.
REQ-021 Cycle after both latched: register effect applied, BVALID asserted, state RESP; BVALID/BRESP held until BREADY, then IDLE.
REQ-022 START write: for each bit i with WDATA[i]=1 and busy[i]=0, start[i] pulses high exactly one cycle, coincident with BVALID rising.
REQ-023 START write with any WDATA[i]=1 where busy[i]=1: that channel not started, other requested idle channels still start, BRESP=SLVERR (2).
REQ-024 DONE[i] SHALL set on done[i]=1; W1C write clears bits with WDATA[i]=1; simultaneous set and clear SHALL leave bit set.
REQ-025 irq SHALL be registered: irq = |(DONE & IRQ_EN), one cycle after DONE/IRQ_EN change.
REQ-026 Read FSM: ARREADY = !RVALID; on AR handshake RDATA/RRESP captured and RVALID asserted next cycle, held stable until RREADY.
REQ-027 Read and write channels SHALL operate concurrently; a same-cycle read of DONE returns the pre-clear value.
REQ-028 Ready signals SHALL not depend combinationally on VALID inputs.

Reset
REQ-029 With resetn=0 all outputs SHALL be 0 immediately (start, irq, AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA); DONE and IRQ_EN cleared; FSMs to IDLE.
REQ-030 Reset mid-transaction SHALL abandon it with no start pulse; first cycle after deassertion AWREADY=WREADY=ARREADY=1.

Verification
REQ-031 NCH=4, busy=0, write 0x5 to addr 0x00 -> start=0101 for one cycle with BVALID, BRESP=0.
REQ-032 busy=0010, write 0x3 to 0x00 -> start=0001 pulse only, BRESP=2.
REQ-033 done[2] pulse, IRQ_EN=0x4 -> read 0x08 returns 0x4, irq=1; write 0x4 to 0x08 -> DONE=0, irq=0 next cycle; done[2] in same cycle as clear -> bit stays 1.
REQ-034 W presented 3 cycles before AW, BREADY held low 5 cycles -> single write, BVALID held 5 cycles, AWREADY/WREADY low meanwhile.
REQ-035 Read 0x40 -> RRESP=3, RDATA=0; write 0x40 -> BRESP=3, no state change.
REQ-036 resetn low during HAVE_AW with IRQ_EN=0xF -> all outputs 0, IRQ_EN reads 0 after release, no start pulse.
